// File: rtl/axi_cmd_engine.sv
// Byte-stream command engine: parses write/read commands from s_axis, runs one AXI4 burst,
// and returns read data plus a one-byte status packet on m_axis.
module axi_cmd_engine #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast
);

  localparam int unsigned AddrBytes = ADDR_WIDTH / 8;
  localparam int unsigned DataBytes = DATA_WIDTH / 8;
  localparam int unsigned ToWidth   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0]         AxSize   = 3'($clog2(DataBytes));
  localparam logic [3:0]         HdrLast  = 4'(AddrBytes + 1);
  localparam logic [3:0]         BeatLast = 4'(DataBytes - 1);
  localparam logic [ToWidth-1:0] ToLast   = ToWidth'(TIMEOUT - 1);

  localparam logic [7:0] OpWrite      = 8'h01;
  localparam logic [7:0] OpRead       = 8'h02;
  localparam logic [7:0] StatBadOp    = 8'hE0;
  localparam logic [7:0] StatTooLong  = 8'hE1;
  localparam logic [7:0] StatTimeout  = 8'hE2;
  localparam logic [7:0] StatShort    = 8'hE3;

  typedef enum logic [3:0] {
    StIdle, StHdr, StAw, StWcol, StWsend, StBwait, StAr, StRwait, StRser, StStat, StDrain
  } state_e;

  state_e                 state_q;
  logic                   run_q;
  logic [7:0]             opcode_q;
  logic [7:0]             len_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [3:0]             byte_cnt_q;
  logic [7:0]             beat_cnt_q;
  logic                   in_done_q;
  logic                   last_beat_q;
  logic [7:0]             status_q;
  logic [DATA_WIDTH-1:0]  rbuf_q;
  logic [ToWidth-1:0]     to_cnt_q;

  logic s_in, wait_st, hs, timeout_hit, too_long;

  function automatic logic [7:0] worst(input logic [7:0] cur, input logic [1:0] resp);
    return ({6'b0, resp} > cur) ? {6'b0, resp} : cur;
  endfunction

  // run_q keeps tready low for the cycle right after reset is released.
  assign s_axis_tready = run_q && (state_q inside {StIdle, StHdr, StWcol, StDrain});
  assign s_in          = s_axis_tvalid && s_axis_tready;

  assign wait_st = state_q inside {StAw, StWsend, StBwait, StAr, StRwait};
  assign hs      = (state_q == StAw    && m_axi_awready) ||
                   (state_q == StWsend && m_axi_wready)  ||
                   (state_q == StBwait && m_axi_bvalid)  ||
                   (state_q == StAr    && m_axi_arready) ||
                   (state_q == StRwait && m_axi_rvalid);
  assign timeout_hit = (TIMEOUT != 0) && wait_st && !hs && (to_cnt_q == ToLast);
  assign too_long    = ({1'b0, len_q} + 9'd1) > 9'(MAX_LEN);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_awsize  = AxSize;
  assign m_axi_arsize  = AxSize;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wstrb   = '1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      run_q         <= 1'b0;
      opcode_q      <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      byte_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      in_done_q     <= 1'b0;
      last_beat_q   <= 1'b0;
      status_q      <= '0;
      rbuf_q        <= '0;
      to_cnt_q      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      to_cnt_q <= (wait_st && !hs) ? to_cnt_q + 1'b1 : '0;
      unique case (state_q)
        StIdle: if (s_in) begin
          opcode_q   <= s_axis_tdata;
          byte_cnt_q <= 4'd1;
          beat_cnt_q <= '0;
          status_q   <= '0;
          in_done_q  <= 1'b0;
          if (s_axis_tlast) begin
            status_q <= StatShort;
            state_q  <= StStat;
          end else begin
            state_q <= StHdr;
          end
        end
        StHdr: if (s_in) begin
          byte_cnt_q <= byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd1) len_q <= s_axis_tdata;
          else addr_q <= ADDR_WIDTH'({s_axis_tdata, addr_q} >> 8);
          if (byte_cnt_q == HdrLast) begin
            byte_cnt_q <= '0;
            if (opcode_q != OpWrite && opcode_q != OpRead) begin
              status_q <= StatBadOp;
              state_q  <= s_axis_tlast ? StStat : StDrain;
            end else if (too_long) begin
              status_q <= StatTooLong;
              state_q  <= s_axis_tlast ? StStat : StDrain;
            end else if (opcode_q == OpWrite) begin
              if (s_axis_tlast) begin
                status_q <= StatShort;
                state_q  <= StStat;
              end else begin
                m_axi_awvalid <= 1'b1;
                state_q       <= StAw;
              end
            end else begin
              in_done_q     <= s_axis_tlast;
              m_axi_arvalid <= 1'b1;
              state_q       <= StAr;
            end
          end else if (s_axis_tlast) begin
            status_q <= StatShort;
            state_q  <= StStat;
          end
        end
        StAw: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          state_q       <= StWcol;
        end
        StWcol: if (s_in) begin
          m_axi_wdata <= DATA_WIDTH'({s_axis_tdata, m_axi_wdata} >> 8);
          if (byte_cnt_q == BeatLast) begin
            byte_cnt_q <= '0;
            if (s_axis_tlast && beat_cnt_q != len_q) begin
              status_q <= StatShort;
              state_q  <= StStat;
            end else begin
              in_done_q    <= s_axis_tlast;
              m_axi_wvalid <= 1'b1;
              m_axi_wlast  <= (beat_cnt_q == len_q);
              state_q      <= StWsend;
            end
          end else begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (s_axis_tlast) begin
              status_q <= StatShort;
              state_q  <= StStat;
            end
          end
        end
        StWsend: if (m_axi_wready) begin
          m_axi_wvalid <= 1'b0;
          m_axi_wlast  <= 1'b0;
          if (m_axi_wlast) begin
            m_axi_bready <= 1'b1;
            state_q      <= StBwait;
          end else begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            state_q    <= StWcol;
          end
        end
        StBwait: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          status_q     <= worst(status_q, m_axi_bresp);
          state_q      <= in_done_q ? StStat : StDrain;
        end
        StAr: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state_q       <= StRwait;
        end
        StRwait: if (m_axi_rvalid) begin
          m_axi_rready  <= 1'b0;
          status_q      <= worst(status_q, m_axi_rresp);
          // An early rlast ends the burst just like the Nth beat would.
          last_beat_q   <= m_axi_rlast || (beat_cnt_q == len_q);
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= m_axi_rdata[7:0];
          rbuf_q        <= m_axi_rdata >> 8;
          byte_cnt_q    <= '0;
          state_q       <= StRser;
        end
        StRser: if (m_axis_tvalid && m_axis_tready) begin
          if (byte_cnt_q == BeatLast) begin
            m_axis_tvalid <= 1'b0;
            byte_cnt_q    <= '0;
            if (last_beat_q) begin
              state_q <= in_done_q ? StStat : StDrain;
            end else begin
              beat_cnt_q   <= beat_cnt_q + 8'd1;
              m_axi_rready <= 1'b1;
              state_q      <= StRwait;
            end
          end else begin
            byte_cnt_q   <= byte_cnt_q + 4'd1;
            m_axis_tdata <= rbuf_q[7:0];
            rbuf_q       <= rbuf_q >> 8;
          end
        end
        StStat: begin
          if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= status_q;
            m_axis_tlast  <= 1'b1;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StDrain: if (s_in && s_axis_tlast) state_q <= StStat;
        default: state_q <= StIdle;
      endcase
      // Abort overrides whatever the wait state decided this cycle.
      if (timeout_hit) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        status_q      <= StatTimeout;
        state_q       <= in_done_q ? StStat : StDrain;
      end
    end
  end

endmodule

// File: tb/tb_axi_cmd_engine.sv
// Directed bench for axi_cmd_engine: write, read, error codes, timeout, stalls and reset abort.
module tb_axi_cmd_engine;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  int checks = 0;
  int errors = 0;
  int axi_valid_cnt = 0;
  int start_cnt;
  int n;

  axi_cmd_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LEN(16), .TIMEOUT(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m_axi_awvalid || m_axi_arvalid || m_axi_wvalid) axi_valid_cnt <= axi_valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
    chk({tag, "_wvalid"}, m_axi_wvalid, 1'b0);
    chk({tag, "_bready"}, m_axi_bready, 1'b0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    chk({tag, "_rready"}, m_axi_rready, 1'b0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
    chk({tag, "_s_tready"}, s_axis_tready, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int k = 0;
    @(negedge aclk);
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = l;
    while (!s_axis_tready && k < 50) begin
      @(negedge aclk);
      k++;
    end
    chk("s_tready_wait", s_axis_tready, 1'b1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [7:0] len, input logic [31:0] a,
                          input logic l);
    send_byte(op, 1'b0);
    send_byte(len, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], l && (i == 3));
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], l && (i == 3));
  endtask

  task automatic expect_aw(input logic [31:0] a, input logic [7:0] len);
    int k = 0;
    @(negedge aclk);
    while (!m_axi_awvalid && k < 50) begin @(negedge aclk); k++; end
    chk("aw_valid", m_axi_awvalid, 1'b1);
    chk("aw_addr", m_axi_awaddr, a);
    chk("aw_len", m_axi_awlen, len);
    chk("aw_size", m_axi_awsize, 3'd2);
    chk("aw_burst", m_axi_awburst, 2'b01);
    m_axi_awready = 1'b1; @(posedge aclk); #1; m_axi_awready = 1'b0;
  endtask

  task automatic expect_w(input logic [31:0] d, input logic l);
    int k = 0;
    @(negedge aclk);
    while (!m_axi_wvalid && k < 50) begin @(negedge aclk); k++; end
    chk("w_valid", m_axi_wvalid, 1'b1);
    chk("w_data", m_axi_wdata, d);
    chk("w_strb", m_axi_wstrb, 4'hF);
    chk("w_last", m_axi_wlast, l);
    m_axi_wready = 1'b1; @(posedge aclk); #1; m_axi_wready = 1'b0;
  endtask

  task automatic give_b(input logic [1:0] resp);
    int k = 0;
    @(negedge aclk);
    while (!m_axi_bready && k < 50) begin @(negedge aclk); k++; end
    chk("b_ready", m_axi_bready, 1'b1);
    m_axi_bvalid = 1'b1; m_axi_bresp = resp;
    @(posedge aclk); #1; m_axi_bvalid = 1'b0;
  endtask

  task automatic expect_ar(input logic [31:0] a, input logic [7:0] len);
    int k = 0;
    @(negedge aclk);
    while (!m_axi_arvalid && k < 50) begin @(negedge aclk); k++; end
    chk("ar_valid", m_axi_arvalid, 1'b1);
    chk("ar_addr", m_axi_araddr, a);
    chk("ar_len", m_axi_arlen, len);
    chk("ar_size", m_axi_arsize, 3'd2);
    chk("ar_burst", m_axi_arburst, 2'b01);
    m_axi_arready = 1'b1; @(posedge aclk); #1; m_axi_arready = 1'b0;
  endtask

  task automatic give_r(input logic [31:0] d, input logic [1:0] resp, input logic l);
    int k = 0;
    @(negedge aclk);
    while (!m_axi_rready && k < 50) begin @(negedge aclk); k++; end
    chk("r_ready", m_axi_rready, 1'b1);
    m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rresp = resp; m_axi_rlast = l;
    @(posedge aclk); #1; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  // While stalled, the byte on m_axis must keep matching the expected value.
  task automatic recv_byte(input string tag, input logic [7:0] d, input logic l, input bit rnd);
    int k = 0;
    bit seen = 0;
    bit done = 0;
    while (!done && k < 100) begin
      @(negedge aclk);
      m_axis_tready = 1'b0;
      if (seen) chk({tag, "_hold"}, m_axis_tvalid, 1'b1);
      if (m_axis_tvalid) begin
        seen = 1;
        chk({tag, "_data"}, m_axis_tdata, d);
        chk({tag, "_last"}, m_axis_tlast, l);
        if (!rnd || $urandom_range(0, 2) != 0) begin
          m_axis_tready = 1'b1; @(posedge aclk); #1; m_axis_tready = 1'b0;
          done = 1;
        end
      end
      k++;
    end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  task automatic recv_word(input string tag, input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) recv_byte(tag, w[8*i +: 8], 1'b0, rnd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;

    // Reset state and first-cycle tready.
    repeat (3) @(negedge aclk);
    chk_quiet("rst");
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_tready_rise", s_axis_tready, 1'b1);

    // Single-beat write.
    send_hdr(8'h01, 8'h00, 32'h4000_0010, 1'b0);
    expect_aw(32'h4000_0010, 8'h00);
    send_word(32'hDEAD_BEEF, 1'b1);
    expect_w(32'hDEAD_BEEF, 1'b1);
    give_b(2'b00);
    recv_byte("wr_stat", 8'h00, 1'b1, 0);
    @(negedge aclk);
    chk("wr_idle_tvalid", m_axis_tvalid, 1'b0);

    // Two-beat read.
    send_hdr(8'h02, 8'h01, 32'h4000_0000, 1'b1);
    expect_ar(32'h4000_0000, 8'h01);
    give_r(32'h1122_3344, 2'b00, 1'b0);
    recv_word("rd_b0", 32'h1122_3344, 0);
    give_r(32'h5566_7788, 2'b00, 1'b1);
    recv_word("rd_b1", 32'h5566_7788, 0);
    recv_byte("rd_stat", 8'h00, 1'b1, 0);

    // Bad opcode, over-long burst, premature tlast: none may touch AXI.
    start_cnt = axi_valid_cnt;
    send_hdr(8'h07, 8'h00, 32'h0, 1'b1);
    recv_byte("badop", 8'hE0, 1'b1, 0);
    chk("badop_no_axi", axi_valid_cnt - start_cnt, 0);
    start_cnt = axi_valid_cnt;
    send_hdr(8'h01, 8'h10, 32'h4000_0000, 1'b0);
    send_word(32'h0, 1'b1);
    recv_byte("toolong", 8'hE1, 1'b1, 0);
    chk("toolong_no_axi", axi_valid_cnt - start_cnt, 0);
    start_cnt = axi_valid_cnt;
    send_hdr(8'h01, 8'h00, 32'h4000_0000, 1'b1);
    recv_byte("short", 8'hE3, 1'b1, 0);
    chk("short_no_axi", axi_valid_cnt - start_cnt, 0);

    // AW never accepted: valid held for exactly 8 cycles, then drain to tlast.
    send_hdr(8'h01, 8'h00, 32'h4000_0000, 1'b0);
    n = 0;
    @(negedge aclk);
    while (m_axi_awvalid && n < 50) begin n++; @(negedge aclk); end
    chk("to_aw_cycles", n, 8);
    send_word(32'h1234_5678, 1'b1);
    recv_byte("to_stat", 8'hE2, 1'b1, 0);

    // Worst rresp wins; m_axis stalled at random.
    send_hdr(8'h02, 8'h01, 32'h0000_1000, 1'b1);
    expect_ar(32'h0000_1000, 8'h01);
    give_r(32'hA1B2_C3D4, 2'b10, 1'b0);
    recv_word("rnd_b0", 32'hA1B2_C3D4, 1);
    give_r(32'h0F1E_2D3C, 2'b00, 1'b1);
    recv_word("rnd_b1", 32'h0F1E_2D3C, 1);
    recv_byte("rnd_stat", 8'h02, 1'b1, 1);

    // Reset in the middle of collecting write data: no response afterwards.
    send_hdr(8'h01, 8'h00, 32'h4000_0000, 1'b0);
    expect_aw(32'h4000_0000, 8'h00);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    chk_quiet("midrst");
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_tready_rise", s_axis_tready, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) n++;
    end
    chk("midrst_no_resp", n, 0);

    // Next command is a normal two-beat write with SLVERR-free OKAY/EXOKAY mix.
    send_hdr(8'h01, 8'h01, 32'h0000_0020, 1'b0);
    expect_aw(32'h0000_0020, 8'h01);
    send_word(32'h0403_0201, 1'b0);
    expect_w(32'h0403_0201, 1'b0);
    send_word(32'h0807_0605, 1'b1);
    expect_w(32'h0807_0605, 1'b1);
    give_b(2'b01);
    recv_byte("wr2_stat", 8'h01, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
